// File: rtl/dual_port_mem_arb_if.sv
// rtl/dual_port_mem_arb_if.sv - instruction/data port bundle for the shared memory arbiter
//
// Purpose: groups the instruction-fetch and load/store handshakes that reach
// dual_port_mem_arb. The master side is the core; the slave side is the memory.
//
// Signals:
//   i_request / i_address              instruction read request and word address
//   i_valid / i_data_out               instruction completion pulse and fetched word
//   d_request / d_we_re / d_mask       data request, 1=write 0=read, byte-lane enables
//   d_address / d_data_in              data word address and write data
//   d_valid / d_data_out               data completion pulse and read word
interface dual_port_mem_arb_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int MASK_W = DATA_W / 8;

  logic              i_request;
  logic [ADDR_W-1:0] i_address;
  logic              i_valid;
  logic [DATA_W-1:0] i_data_out;

  logic              d_request;
  logic              d_we_re;
  logic [MASK_W-1:0] d_mask;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_data_in;
  logic              d_valid;
  logic [DATA_W-1:0] d_data_out;

  modport master (
    output i_request, i_address,
    output d_request, d_we_re, d_mask, d_address, d_data_in,
    input  i_valid, i_data_out, d_valid, d_data_out
  );

  modport slave (
    input  i_request, i_address,
    input  d_request, d_we_re, d_mask, d_address, d_data_in,
    output i_valid, i_data_out, d_valid, d_data_out
  );
endinterface

// File: rtl/dual_port_mem_arb.sv
// rtl/dual_port_mem_arb.sv - unified instruction/data memory with arbitration and wait states
//
// Purpose: one storage array shared by a read-only instruction port and a
// read/byte-masked-write data port. An IDLE/WAIT/RESP FSM serves one access at
// a time; valid pulses LATENCY cycles after acceptance, followed by a
// mandatory IDLE cycle.
//
// Ports:
//   clk   clock, all state on the rising edge
//   rst   asynchronous active-low reset
//   bus   slave side of dual_port_mem_arb_if (both request/valid ports)
//   busy  high while an access is in flight (FSM not IDLE)
module dual_port_mem_arb #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1,
  parameter int RR_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  dual_port_mem_arb_if.slave   bus,
  output logic                 busy
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t            r_state, w_next_state;
  logic [CNT_W-1:0]  r_cnt, w_next_cnt;
  logic              r_port;
  logic              r_we;
  logic              r_last_grant;
  logic [ADDR_W-1:0] r_addr;
  logic [MASK_W-1:0] r_mask;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_i_dout;
  logic [DATA_W-1:0] r_d_dout;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_any_req;
  logic              w_grant;
  logic              w_accept;
  logic              w_rd_port;
  logic              w_rd_we;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_load_rd;

  // Arbitration: a lone requester always wins; on contention either the data
  // port has fixed priority or the port that was not granted last wins.
  always_comb begin
    w_any_req = bus.i_request | bus.d_request;
    if (bus.i_request && bus.d_request) begin
      w_grant = (RR_MODE != 0) ? ~r_last_grant : PORT_D;
    end else begin
      w_grant = bus.d_request ? PORT_D : PORT_I;
    end
    w_accept = (r_state == ST_IDLE) && w_any_req;
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_next_cnt   = CNT_INIT;
          w_next_state = (LATENCY > 1) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        w_next_cnt = r_cnt - 1'b1;
        if (r_cnt <= CNT_W'(1)) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Read data is loaded on the edge that enters RESP so the word is already on
  // data_out while valid is high. With LATENCY=1 that edge is the acceptance
  // edge, so the fields come straight from the bus instead of the capture regs.
  always_comb begin
    w_rd_port = (r_state == ST_IDLE) ? w_grant : r_port;
    w_rd_we   = (r_state == ST_IDLE) ? (w_grant & bus.d_we_re) : r_we;
    if (r_state == ST_IDLE) begin
      w_rd_addr = w_grant ? bus.d_address : bus.i_address;
    end else begin
      w_rd_addr = r_addr;
    end
    w_load_rd = (w_next_state == ST_RESP) && (r_state != ST_RESP) && !w_rd_we;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_port       <= PORT_I;
      r_we         <= 1'b0;
      r_last_grant <= PORT_I;
      r_addr       <= '0;
      r_mask       <= '0;
      r_wdata      <= '0;
      r_i_dout     <= '0;
      r_d_dout     <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_accept) begin
        r_port       <= w_grant;
        r_we         <= w_grant & bus.d_we_re;
        r_addr       <= w_grant ? bus.d_address : bus.i_address;
        r_mask       <= bus.d_mask;
        r_wdata      <= bus.d_data_in;
        r_last_grant <= w_grant;
      end
      if (w_load_rd) begin
        if (w_rd_port == PORT_D) begin
          r_d_dout <= r_mem[w_rd_addr];
        end else begin
          r_i_dout <= r_mem[w_rd_addr];
        end
      end
    end
  end

  // The commit happens on the edge that leaves RESP; a reset before that edge
  // has already forced IDLE, so an aborted write never reaches the array.
  always_ff @(posedge clk) begin
    if (r_state == ST_RESP && r_we) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (r_mask[b]) begin
          r_mem[r_addr][b*8 +: 8] <= r_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign bus.i_valid    = (r_state == ST_RESP) && (r_port == PORT_I);
  assign bus.d_valid    = (r_state == ST_RESP) && (r_port == PORT_D);
  assign bus.i_data_out = r_i_dout;
  assign bus.d_data_out = r_d_dout;
  assign busy           = (r_state != ST_IDLE);
endmodule

// File: doc/dual_port_mem_arb.md
Name: dual_port_mem_arb

Overview:
Parametrised unified memory that replaces separate instruction and data memories with one array shared by two request/valid ports. The instruction port is read-only. The data port reads and byte-masked writes. An arbiter serialises the ports with a selectable policy, and a programmable wait-state counter models slow memory. It sits between the core's instruction-fetch/load-store handshakes and the storage array.

Parameters:
DATA_W, 32, word width in bits; multiple of 8; mask width is DATA_W/8.
DEPTH, 256, number of words; power of 2; ADDR_W = clog2(DEPTH) is derived, not overridable.
LATENCY, 1, cycles from request acceptance to valid pulse; legal range 1..8.
RR_MODE, 0, arbitration policy: 0 = fixed data-port priority, 1 = round-robin.

Ports:
clk  input  1  single clock; all state on rising edge.
rst  input  1  asynchronous, active-low reset.
i_request  input  1  instruction-port request; held high until i_valid.
i_address  input  ADDR_W  instruction word address.
i_valid  output  1  one-cycle pulse, instruction read complete.
i_data_out  output  DATA_W  fetched word; held until the next i_valid.
d_request  input  1  data-port request; held high until d_valid.
d_we_re  input  1  1 = write, 0 = read.
d_mask  input  DATA_W/8  byte-lane write enables; ignored on reads.
d_address  input  ADDR_W  data word address.
d_data_in  input  DATA_W  write data.
d_valid  output  1  one-cycle pulse, data access complete.
d_data_out  output  DATA_W  read word; held until the next data-port read completes.
busy  output  1  high while an access is in flight (FSM not IDLE).

Behaviour:
- Reset (rst low, async): FSM to IDLE, wait counter to 0, i_valid/d_valid/busy to 0, i_data_out/d_data_out to 0, last_grant to INSTR. Array contents are not cleared.
- Handshake rules:
  - Requester raises request with stable address/we_re/mask/data and keeps them stable until its valid pulse.
  - Request high in the cycle after valid counts as a new request.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: when any request is high, grant one port and capture its fields, port id, and opcode. Counter loads LATENCY-1. Go to WAIT if LATENCY>1, else RESP. busy goes high the cycle after acceptance.
  - WAIT: decrement counter; at 1, go to RESP. Requests are not sampled.
  - RESP: the granted port's valid is high for exactly this cycle. A read drives that port's data_out from array[captured address]. A write commits array bytes where mask=1, and data_out is unchanged. Next state is IDLE.
  - Result: acceptance at edge T gives valid during cycle T+LATENCY. Back-to-back throughput is one access per LATENCY+1 cycles (mandatory IDLE cycle).
- Arbitration, both requests high in IDLE:
  - RR_MODE=0: data port wins.
  - RR_MODE=1: the port not in last_grant wins; last_grant updates on every acceptance.
  - Single requester always wins. The losing port keeps its request and is served next.
- Write commit happens only in RESP. A subsequent read of the same address, from either port, returns the new data.
- Write with mask=0: valid still pulses, array unchanged.
- Address is exactly ADDR_W bits; no out-of-range case exists.
- Reset mid-operation (WAIT or RESP before the edge): access aborted, no valid pulse, write not committed.
- Request dropped illegally before valid: the captured access still completes and valid still pulses.

Test Plan:
- Defaults: write d_address=5, data 0xDEADBEEF, mask 4'hF, then d_read 5 -> d_valid 1 cycle after each acceptance, d_data_out=0xDEADBEEF.
- Partial write mask 4'b0101 data 0x11223344 over 0xDEADBEEF at addr 5 -> read returns 0xDE22BE44. Mask 0 write -> unchanged.
- Simultaneous i_request (addr 5) and d_request (read addr 6), RR_MODE=0 -> d_valid first, i_valid LATENCY+1 cycles later with i_data_out=0xDE22BE44.
- RR_MODE=1, both ports continuously requesting for 6 accesses -> grants D,I,D,I,D,I (reset last_grant=INSTR).
- LATENCY=4 -> valid exactly 4 cycles after acceptance; busy high for 4 cycles; next acceptance no earlier than cycle 5.
- rst asserted during WAIT of a write to addr 9 -> no valid, all outputs 0, later read of addr 9 returns its prior value.
